// File: rtl/multi_edge_detect.sv
// multi_edge_detect: WIDTH independent channels, each synchronised, optionally
// debounced, and edge-qualified by a 2-bit per-channel mode into a one-cycle
// detection pulse. Define EDGE_STICKY_EN to add per-channel sticky flags,
// their clear inputs and an irq line (OR of the sticky flags).

// One channel: synchroniser -> debounce counter -> level register -> qualifier.
module multi_edge_detect_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 0,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  output logic       detection,
  output logic       level
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   fire;   // level takes the sync value on this edge

  // synchroniser shift register, oldest sample at the top
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEB_CYCLES == 0) begin : g_nodeb
      assign fire = s ^ level;
    end else begin : g_deb
      localparam int            CW   = $clog2(DEB_CYCLES + 1);
      localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES);
      logic [CW-1:0] cnt;

      // counts consecutive edges where sync differs from level; the
      // DEB_CYCLES+1-th such edge accepts the new value
      assign fire = (s ^ level) && (cnt == CMAX);

      // run-length counter, cleared on agreement or on acceptance
      always_ff @(posedge clk or negedge rst)
        if (!rst)                   cnt <= '0;
        else if (!(s ^ level) || fire) cnt <= '0;
        else                        cnt <= cnt + CW'(1);
    end
  endgenerate

  // level register and mode-qualified pulse; mode is looked at on the toggle edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      level     <= RST_LEVEL;
      detection <= 1'b0;
    end else begin
      detection <= fire & (level ? mode[1] : mode[0]);
      if (fire) level <= s;
    end
endmodule

// Top: array of lanes plus optional sticky/irq status.
module multi_edge_detect #(
  parameter int   WIDTH       = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 0,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sig,
  input  logic [2*WIDTH-1:0] mode,
  output logic [WIDTH-1:0]   detection,
`ifdef EDGE_STICKY_EN
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   sticky,
  output logic               irq,
`endif
  output logic [WIDTH-1:0]   level
);
  multi_edge_detect_lane #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES),
    .RST_LEVEL  (RST_LEVEL)
  ) u_lane [WIDTH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .mode     (mode),
    .detection(detection),
    .level    (level)
  );

`ifdef EDGE_STICKY_EN
  // sticky flags: a pulse sets on the following edge, set beats clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) sticky <= '0;
    else      sticky <= detection | (sticky & ~clr);

  // OR of registers only, so irq cannot glitch from inputs
  assign irq = |sticky;
`endif
endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: dut_a (SYNC 2, DEB 3) and dut_b (SYNC 3, DEB 0)
// share clock, reset and inputs; each has its own reference model.
module tb_multi_edge_detect;
  localparam int SA = 2, DA = 3, SB = 3;

  logic       clk = 1'b0, rst = 1'b0;
  logic [3:0] sig = '0, clr = '0;
  logic [7:0] mode = '0;
  logic [3:0] det_a, lvl_a, det_b, lvl_b;
  logic [3:0] stk_a, stk_b;
  logic       irq_a, irq_b;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  multi_edge_detect #(.WIDTH(4), .SYNC_STAGES(SA), .DEB_CYCLES(DA)) dut_a (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .detection(det_a),
`ifdef EDGE_STICKY_EN
    .clr(clr), .sticky(stk_a), .irq(irq_a),
`endif
    .level(lvl_a));

  multi_edge_detect #(.WIDTH(4), .SYNC_STAGES(SB), .DEB_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .detection(det_b),
`ifdef EDGE_STICKY_EN
    .clr(clr), .sticky(stk_b), .irq(irq_b),
`endif
    .level(lvl_b));

`ifndef EDGE_STICKY_EN
  assign stk_a = '0; assign stk_b = '0; assign irq_a = 1'b0; assign irq_b = 1'b0;
`endif

  // ---------------- model A: window over captured history ----------------
  // hqa[j] = sig captured j+1 edges ago. A channel toggles when the last
  // DA+1 values seen at the synchroniser output all differ from its level
  // and at least DA+1 edges have passed since its previous toggle.
  bit [3:0] hqa[$];
  bit [3:0] ml_a, md_a, ms_a, nd_a;
  int       since_a[4];
  bit       all_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hqa = {};
      for (int j = 0; j < SA + DA + 1; j++) hqa.push_front(4'b0);
      ml_a = '0; md_a = '0; ms_a = '0;
      for (int c = 0; c < 4; c++) since_a[c] = 1000;
    end else begin
      ms_a = md_a | (ms_a & ~clr);
      nd_a = '0;
      for (int c = 0; c < 4; c++) begin
        since_a[c]++;
        all_a = 1'b1;
        for (int k = 0; k <= DA; k++)
          if (hqa[SA-1+k][c] == ml_a[c]) all_a = 1'b0;
        if (all_a && since_a[c] >= DA + 1) begin
          nd_a[c]    = ml_a[c] ? mode[2*c+1] : mode[2*c];
          ml_a[c]    = ~ml_a[c];
          since_a[c] = 0;
        end
      end
      md_a = nd_a;
      hqa.push_front(sig);
      while (hqa.size() > SA + DA + 1) void'(hqa.pop_back());
    end
  end

  // ---------------- model B: pure delay line ----------------
  // level is sig delayed by SB edges; detection is the qualified change.
  bit [3:0] hqb[$];
  bit [3:0] ml_b, md_b, chg_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hqb = {};
      for (int j = 0; j < SB + 2; j++) hqb.push_front(4'b0);
      ml_b = '0; md_b = '0;
    end else begin
      hqb.push_front(sig);
      while (hqb.size() > SB + 2) void'(hqb.pop_back());
      ml_b  = hqb[SB];
      chg_b = hqb[SB] ^ hqb[SB+1];
      for (int c = 0; c < 4; c++)
        md_b[c] = chg_b[c] & (hqb[SB][c] ? mode[2*c] : mode[2*c+1]);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; sig = '0; mode = 8'h55; clr = '0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({det_a, lvl_a, det_b, lvl_b, stk_a, irq_a} !== 17'b0) begin
      nerr++;
      $display("FAIL reset: got det_a=%b lvl_a=%b det_b=%b lvl_b=%b stk=%b irq=%b want all 0",
               det_a, lvl_a, det_b, lvl_b, stk_a, irq_a);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_rise_latency();
    repeat (8) @(negedge clk);
    sig = 4'b0001;                      // captured at E0 (k=0)
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      nvec++;
      if (det_a !== ((k == 5) ? 4'b0001 : 4'b0000) ||
          lvl_a !== ((k >= 5) ? 4'b0001 : 4'b0000)) begin
        nerr++;
        $display("FAIL rise_latency k=%0d: det=%b lvl=%b want det=%b lvl=%b", k, det_a, lvl_a,
                 (k == 5) ? 4'b0001 : 4'b0000, (k >= 5) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_glitch();
    int npulse, first, last;
    mode = 8'hFF;
    for (int w = 3; w <= 4; w++) begin
      npulse = 0; first = -1; last = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        sig[1] = (k < w);
        @(posedge clk); #1;
        if (det_a[1]) begin npulse++; if (first < 0) first = k; last = k; end
        nvec++;
        if ({det_a, lvl_a} !== {md_a, ml_a}) begin
          nerr++;
          $display("FAIL glitch w=%0d k=%0d: det=%b lvl=%b want det=%b lvl=%b",
                   w, k, det_a, lvl_a, md_a, ml_a);
        end
      end
      nvec++;
      if (npulse !== ((w == 3) ? 0 : 2) || (w == 4 && last - first != 4)) begin
        nerr++;
        $display("FAIL glitch_count w=%0d: pulses=%0d spacing=%0d want %0d pulses spacing 4",
                 w, npulse, last - first, (w == 3) ? 0 : 2);
      end
    end
  endtask

  task automatic test_modes();
    int cnt[4];
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    @(negedge clk); sig = 4'b0000; repeat (10) @(negedge clk);
    mode = 8'hE4;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      sig = (k < 8) ? 4'b1111 : 4'b0000;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) cnt[c] += det_a[c];
      nvec++;
      if ({det_a, lvl_a} !== {md_a, ml_a}) begin
        nerr++;
        $display("FAIL modes k=%0d: det=%b lvl=%b want det=%b lvl=%b", k, det_a, lvl_a, md_a, ml_a);
      end
      if (k == 12) begin
        nvec++;
        if (lvl_a !== 4'b1111) begin
          nerr++; $display("FAIL modes_level_high: lvl=%b want 1111", lvl_a);
        end
      end
    end
    nvec++;
    if (cnt[0] != 0 || cnt[1] != 1 || cnt[2] != 1 || cnt[3] != 2 || lvl_a !== 4'b0000) begin
      nerr++;
      $display("FAIL modes_count: got %0d %0d %0d %0d lvl=%b want 0 1 1 2 lvl=0000",
               cnt[0], cnt[1], cnt[2], cnt[3], lvl_a);
    end
  endtask

  task automatic test_reset_mid();
    mode = 8'hFF;
    @(negedge clk); sig = 4'b0001; repeat (10) @(negedge clk);
    sig = 4'b0101;                      // ch2 captured at E0
    repeat (4) @(posedge clk);          // after E0+3 the ch2 counter holds 2
    #3 rst = 1'b0;
    #1;
    nvec++;
    if (lvl_a !== 4'b0000 || det_a !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_mid: lvl=%b det=%b want lvl=0000 det=0000", lvl_a, det_a);
    end
    @(negedge clk); rst = 1'b1;         // next posedge is the new E0
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      nvec++;
      if (det_a[2] !== (k == 5) || {det_a, lvl_a} !== {md_a, ml_a}) begin
        nerr++;
        $display("FAIL reset_mid_rise k=%0d: det=%b lvl=%b want det=%b lvl=%b ch2=%b",
                 k, det_a, lvl_a, md_a, ml_a, (k == 5));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      sig  = 4'($urandom);
      mode = 8'($urandom);
      @(posedge clk); #1;
      nvec++;
      if ({det_b, lvl_b} !== {md_b, ml_b} || {det_a, lvl_a} !== {md_a, ml_a}) begin
        nerr++;
        $display("FAIL random k=%0d: b det=%b lvl=%b want %b %b; a det=%b lvl=%b want %b %b",
                 k, det_b, lvl_b, md_b, ml_b, det_a, lvl_a, md_a, ml_a);
      end
    end
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) sig = 4'($urandom);
      if ($urandom_range(7) == 0) mode = 8'($urandom);
      @(posedge clk); #1;
      nvec++;
      if ({det_b, lvl_b} !== {md_b, ml_b} || {det_a, lvl_a} !== {md_a, ml_a}) begin
        nerr++;
        $display("FAIL random_hold k=%0d: b det=%b lvl=%b want %b %b; a det=%b lvl=%b want %b %b",
                 k, det_b, lvl_b, md_b, ml_b, det_a, lvl_a, md_a, ml_a);
      end
    end
  endtask

`ifdef EDGE_STICKY_EN
  task automatic test_sticky();
    mode = 8'hFF; clr = 4'hF;
    @(negedge clk); sig = 4'b0000; repeat (10) @(negedge clk);
    clr = '0;
    sig = 4'b1000;                      // rise on ch3 captured at E0
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      nvec++;
      if (stk_a !== ms_a || irq_a !== (|ms_a) || det_a !== md_a) begin
        nerr++;
        $display("FAIL sticky_set k=%0d: stk=%b irq=%b det=%b want stk=%b irq=%b det=%b",
                 k, stk_a, irq_a, det_a, ms_a, |ms_a, md_a);
      end
      @(negedge clk);
      clr = (k == 10) ? 4'b1000 : 4'b0000;
    end
    nvec++;
    if (stk_a !== 4'b0000 || irq_a !== 1'b0) begin
      nerr++; $display("FAIL sticky_clear: stk=%b irq=%b want 0000 0", stk_a, irq_a);
    end
    sig = 4'b0000;                      // fall on ch3 captured at E0
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        nvec++;
        if (stk_a[3] !== 1'b1 || irq_a !== 1'b1) begin
          nerr++; $display("FAIL sticky_set_wins: stk=%b irq=%b want stk[3]=1 irq=1", stk_a, irq_a);
        end
      end
      @(negedge clk);
      clr = (k == 5) ? 4'b1000 : 4'b0000;   // clr high at E0+6, same edge as the set
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_modes();
    test_reset_mid();
    test_random();
`ifdef EDGE_STICKY_EN
    test_sticky();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end
endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Parametrised multi-channel edge detector, successor to the single-bit change detector. Each of WIDTH asynchronous input lines is synchronised, optionally debounced, and checked for rising, falling or both edges under a per-channel mode. Every qualified edge produces a one-cycle pulse. Optional sticky status flags with an interrupt line let a controller poll or service events. The block sits between raw external/status signals and control FSMs or an interrupt aggregator.

## Interface
- WIDTH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEB_CYCLES, 0: debounce length; 0 = debounce bypassed
- RST_LEVEL, 1'b0: reset value of every filtered level bit
- clk  in  1  single clock, all flops rising-edge
- rst  in  1  asynchronous, active-low reset
- sig  in  WIDTH  raw, asynchronous input lines
- mode  in  2*WIDTH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- detection  out  WIDTH  registered one-cycle edge pulse per channel
- level  out  WIDTH  registered filtered (synchronised, debounced) level
- clr  in  WIDTH  sticky clear, per channel (EDGE_STICKY_EN only)
- sticky  out  WIDTH  sticky event flags (EDGE_STICKY_EN only)
- irq  out  1  OR of all sticky bits (EDGE_STICKY_EN only)

## Operation
- Per channel: SYNC_STAGES-deep shift register → debounce counter → level register → edge qualifier.
- Debounce counter width $clog2(DEB_CYCLES+1). It clears on any edge where sync output equals level. It increments while sync output differs from level.
- level[i] toggles at the edge where sync output has differed from level on DEB_CYCLES+1 consecutive edges. The counter clears on that same edge.
- Pulses at the sync output shorter than DEB_CYCLES+1 cycles are rejected, and level does not change.
- DEB_CYCLES=0: level follows the sync output with one register stage, and no counter is generated.
- detection[i] is asserted on the same edge that level[i] toggles, when the mode qualifies it. A 0→1 toggle needs mode 01 or 11. A 1→0 toggle needs mode 10 or 11. Mode 00 never asserts detection.
- detection[i] is high for exactly one cycle per toggle. It is never held, because a second toggle needs at least DEB_CYCLES+1 further cycles.
- mode is sampled at the toggle edge. A mode change only affects toggles from the next edge onward, and level tracks regardless of mode.
- Channels are fully independent. Simultaneous edges on several channels give simultaneous pulses.
- Reset (asynchronous assert, any time including mid-debounce): sync flops 0, counters 0, level = RST_LEVEL, detection 0, sticky 0, irq 0.
- Reset release: no pulse is generated for the reset itself. An input already differing from RST_LEVEL yields a normal, qualified edge after the full latency.

## Timing
- Latency: sig is stable before capture edge E0. level and detection change at edge E0+SYNC_STAGES+DEB_CYCLES.
- Example: SYNC_STAGES=2, DEB_CYCLES=0 gives output at E0+2, which is 3 edges counting E0.
- Minimum accepted input pulse width: DEB_CYCLES+1 clock periods at the sync output.
- Sticky: set at the edge after detection is high. Cleared at the edge where clr[i] is sampled high.
- Sticky set and clear on the same edge: set wins.
- irq is a combinational OR of sticky registers and is glitch-free.
- No combinational path from sig, mode or clr to any output.

## Configuration
- EDGE_STICKY_EN defined: clr, sticky and irq ports and logic are present.
- EDGE_STICKY_EN undefined: those ports and that logic are absent. detection and level behaviour is unchanged.

## Test plan
All cases use WIDTH=4, SYNC_STAGES=2, DEB_CYCLES=3 unless stated.
- Reset with sig=4'b0000, release, then sig[0] 0→1 held with mode=8'h55 → level[0]=1 and detection[0]=1 for one cycle at E0+5. Other channels stay 0.
- sig[1] high for 3 cycles, then low, mode both → level[1] and detection[1] never change. Repeat with a 4-cycle pulse → one rise pulse and one fall pulse, 4 cycles apart.
- mode=8'hE4 (ch0 off, ch1 rise, ch2 fall, ch3 both); toggle all four 0→1→0 with 8-cycle holds → ch0: 0 pulses, ch1: 1 pulse, ch2: 1 pulse, ch3: 2 pulses. level follows on all four.
- rst asserted while ch2 is mid-debounce (counter=2) → immediate level=RST_LEVEL and detection=0. After release with sig[2]=1 → one rise pulse at full latency, not earlier.
- EDGE_STICKY_EN: ch3 edge gives sticky[3]=1 and irq=1. clr[3] pulse gives sticky[3]=0 and irq=0. A new edge on the same cycle as clr[3] → sticky[3] stays 1.
- DEB_CYCLES=0, SYNC_STAGES=3: 25 random sig values at 1-cycle holds → detection equals the qualified XOR of level and its previous value each cycle, lagging sig by 3 edges.
